sevenseg_scan_reader: RTL and testbench
=======================================

SEVENSEG_SCAN_READER -- requirements
Module: sevenseg_scan_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive identical synchronized samples needed to accept a digit (legal range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port an  input  4  digit enables, active-low, one-hot when a digit is driven; an[i] selects digit i.
REQ-005 SHALL have port seg  input  7  segment lines, active-high, bit order {g,f,e,d,c,b,a}.
REQ-006 SHALL have port digits  output  16  last committed frame; digits[4i+3:4i] = digit i.
REQ-007 SHALL have port valid  output  1  high once at least one frame has committed.
REQ-008 SHALL have port frame_done  output  1  one-cycle pulse on each commit.
REQ-009 SHALL have port seg_err  output  1  committed frame contained an unrecognised pattern; updated at commit.
REQ-010 SHALL have port an_err  output  1  sticky: more than one an bit was low on a synchronized sample.

Function
REQ-011 SHALL pass an and seg through a two-flop synchronizer; all later logic uses the synchronized values (an_s, seg_s).
REQ-012 SHALL decode seg_s with table 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (hex, bit6=g); any other pattern is unrecognised, decodes to nibble 0, and sets that slot's bad bit.
REQ-013 SHALL keep an 8-bit stability counter: reset to 0 when {an_s,seg_s} differs from the previous cycle's sample, otherwise increment, saturating at STABLE_CYCLES.
REQ-014 SHALL capture the decoded nibble into shadow slot i in the cycle the counter reaches STABLE_CYCLES-1 with an_s one-hot low at bit i; latency pin change -> shadow update = 2+STABLE_CYCLES clock edges.
REQ-015 SHALL capture at most once per dwell; no new capture until {an_s,seg_s} changes and re-stabilises.
REQ-016 SHALL treat an_s=4'hF (blanking) as no digit: no capture, no error, counter still tracks.
REQ-017 SHALL treat an_s with two or more bits low as illegal: no capture, an_err set and held until reset.
REQ-018 SHALL overwrite a slot (nibble and bad bit) if recaptured before the frame commits.
REQ-019 SHALL implement FSM IDLE -> ACCUM on first capture; ACCUM -> COMMIT when the captured mask reaches 4'b1111; COMMIT -> ACCUM unconditionally after one cycle.
REQ-020 SHALL, in COMMIT, load digits from the shadow slots, set valid, pulse frame_done, load seg_err as OR of the four bad bits, and clear mask and bad bits.
REQ-021 SHALL, when a capture coincides with COMMIT, apply the capture to the freshly cleared mask, so it counts toward the next frame.
REQ-022 SHALL leave digits, valid, seg_err unchanged between commits.

Reset
REQ-023 SHALL, while reset is high on a clock edge, clear synchronizers, counter, shadow slots, mask, bad bits, digits=16'h0000, valid=0, frame_done=0, seg_err=0, an_err=0, state=IDLE.
REQ-024 SHALL discard a partially captured frame on reset mid-operation; the next commit requires four fresh captures.

Verification
REQ-025 Scan an=E,D,B,7 with seg=06,5B,4F,66, 8 cycles each, STABLE_CYCLES=4 -> one frame_done pulse, digits=16'h4321, valid=1, seg_err=0.
REQ-026 Same scan, digit 2 held only 3 cycles -> no capture of slot 2, no commit until a later 4-cycle dwell on an=B.
REQ-027 Scan with slot 1 seg=7'h00 -> commit with digits[7:4]=0, seg_err=1; next clean frame -> seg_err=0.
REQ-028 Apply an=4'hC for 6 cycles mid-scan -> an_err=1 and stays 1; no capture for that dwell; frame still completes on valid digits.
REQ-029 Capture slots 0 and 1, assert reset 1 cycle, then capture slots 2 and 3 -> no frame_done; all outputs zero until four fresh captures commit.
REQ-030 Continuous scan of 16'hF0A5 with blanking cycles (an=F) between digits -> frame_done every full rotation, digits=16'hF0A5, an_err=0.

Source files
------------

// File: rtl/sevenseg_scan_reader.sv
// Recovers the four digits shown on a multiplexed common-anode 7-segment display
// by sampling its an/seg lines, debouncing each dwell and committing whole frames.
module sevenseg_scan_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic        valid,
  output logic        frame_done,
  output logic        seg_err,
  output logic        an_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;

  localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES);
  localparam logic [7:0] CAP_AT  = 8'(STABLE_CYCLES - 2);

  state_t      state, state_next;
  logic [3:0]  an_m, an_s, an_p;
  logic [6:0]  seg_m, seg_s, seg_p;
  logic [1:0]  samp_v;
  logic [7:0]  cnt;
  logic [15:0] shadow;
  logic [3:0]  mask, bad;

  logic        same, onehot, blank, illegal, capture, unknown;
  logic [1:0]  slot;
  logic [3:0]  nib, sel, mask_base, bad_base;

  always_comb begin
    unknown = 1'b0;
    nib     = '0;
    case (seg_s)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: unknown = 1'b1;
    endcase
  end

  always_comb begin
    onehot = 1'b0;
    slot   = '0;
    case (an_s)
      4'b1110: begin onehot = 1'b1; slot = 2'd0; end
      4'b1101: begin onehot = 1'b1; slot = 2'd1; end
      4'b1011: begin onehot = 1'b1; slot = 2'd2; end
      4'b0111: begin onehot = 1'b1; slot = 2'd3; end
      default: ;
    endcase
    blank   = (an_s == 4'hF);
    illegal = !onehot && !blank;
    same    = ({an_s, seg_s} == {an_p, seg_p});
    // Capture on the edge that moves the counter to STABLE_CYCLES-1; samp_v masks
    // the cleared synchronizer contents that follow reset.
    capture = samp_v[1] && same && (cnt == CAP_AT) && onehot;
    sel     = capture ? 4'(4'b0001 << slot) : '0;
    mask_base = (state == COMMIT) ? '0 : mask;
    bad_base  = (state == COMMIT) ? '0 : bad;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = ACCUM;
      ACCUM:   if (mask == 4'hF) state_next = COMMIT;
      COMMIT:  state_next = ACCUM;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_m       <= '0;
      an_s       <= '0;
      an_p       <= '0;
      seg_m      <= '0;
      seg_s      <= '0;
      seg_p      <= '0;
      samp_v     <= '0;
      cnt        <= '0;
      shadow     <= '0;
      mask       <= '0;
      bad        <= '0;
      digits     <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      an_err     <= 1'b0;
    end else begin
      an_m   <= an;
      an_s   <= an_m;
      an_p   <= an_s;
      seg_m  <= seg;
      seg_s  <= seg_m;
      seg_p  <= seg_s;
      samp_v <= {samp_v[0], 1'b1};

      if (!same)              cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + 8'd1;

      if (capture) shadow[{slot, 2'b00} +: 4] <= nib;
      mask <= mask_base | sel;
      bad  <= (bad_base & ~sel) | (unknown ? sel : '0);

      frame_done <= 1'b0;
      if (state == COMMIT) begin
        digits     <= shadow;
        valid      <= 1'b1;
        frame_done <= 1'b1;
        seg_err    <= |bad;
      end

      if (samp_v[1] && illegal) an_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// Directed bench for sevenseg_scan_reader: a latency-level model of the display
// reader is compared against the DUT every cycle, plus hand-computed frame values.
module tb_sevenseg_scan_reader;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic        valid, frame_done, seg_err, an_err;

  always #5 clk = ~clk;

  sevenseg_scan_reader #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .an(an), .seg(seg), .digits(digits),
    .valid(valid), .frame_done(frame_done), .seg_err(seg_err), .an_err(an_err)
  );

  int checks = 0;
  int failures = 0;
  int frames = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a digit is read when its pin pattern has been seen S times in a row;
  // everything derived from a pin sample shows up two edges later, and a frame
  // appears on the outputs two edges after its fourth slot is read.
  typedef struct packed {
    logic       v;
    logic       ill;
    logic       cap;
    logic [1:0] slot;
    logic [3:0] nib;
    logic       bad;
  } eff_t;

  logic [6:0]  codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          run = 0;
  int          due = 0;
  logic [10:0] prev = '0;
  eff_t        pipe0 = '0, pipe1 = '0, e;
  logic [3:0]  m_sh [4] = '{default: 4'h0};
  logic [3:0]  m_mask = '0, m_bad = '0;
  logic [15:0] x_digits = '0;
  logic        x_valid = 1'b0, x_fd = 1'b0, x_se = 1'b0, x_ae = 1'b0;

  function automatic eff_t classify(input logic [3:0] a, input logic [6:0] s, input int r);
    eff_t ef;
    logic [3:0] t;
    ef = '0;
    ef.v   = 1'b1;
    ef.ill = ($countones(~a) >= 2);
    ef.bad = 1'b1;
    for (int k = 0; k < 16; k++)
      if (codes[k] == s) begin
        ef.nib = 4'(k);
        ef.bad = 1'b0;
      end
    for (int i = 0; i < 4; i++) begin
      t = 4'hF;
      t[i] = 1'b0;
      if (a == t && r == S) begin
        ef.cap  = 1'b1;
        ef.slot = 2'(i);
      end
    end
    return ef;
  endfunction

  always begin
    @(posedge clk);
    if (reset) begin
      run = 0; due = 0; pipe0 = '0; pipe1 = '0;
      for (int i = 0; i < 4; i++) m_sh[i] = 4'h0;
      m_mask = '0; m_bad = '0;
      x_digits = '0; x_valid = 1'b0; x_fd = 1'b0; x_se = 1'b0; x_ae = 1'b0;
    end else begin
      x_fd = 1'b0;
      e = pipe1;
      pipe1 = pipe0;
      if (run > 0 && {an, seg} == prev) begin
        if (run <= S) run++;
      end else run = 1;
      prev = {an, seg};
      pipe0 = classify(an, seg, run);
      if (due > 0) begin
        due--;
        if (due == 0) begin
          for (int i = 0; i < 4; i++) x_digits[4*i +: 4] = m_sh[i];
          x_valid = 1'b1; x_fd = 1'b1; x_se = |m_bad;
          m_mask = '0; m_bad = '0;
        end
      end
      if (e.v) begin
        if (e.ill) x_ae = 1'b1;
        if (e.cap) begin
          m_sh[e.slot] = e.nib;
          m_mask[e.slot] = 1'b1;
          m_bad[e.slot] = e.bad;
        end
      end
      if (m_mask == 4'hF && due == 0) due = 2;
    end
  end

  always begin
    @(negedge clk);
    chk("digits", digits, x_digits);
    chk("valid", 16'(valid), 16'(x_valid));
    chk("frame_done", 16'(frame_done), 16'(x_fd));
    chk("seg_err", 16'(seg_err), 16'(x_se));
    chk("an_err", 16'(an_err), 16'(x_ae));
    if (frame_done === 1'b1) frames++;
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    hold(4'hE, s0, 8);
    hold(4'hD, s1, 8);
    hold(4'hB, s2, 8);
    hold(4'h7, s3, 8);
    hold(4'hF, 7'h00, 6);
  endtask

  initial begin
    reset = 1'b1;
    an = 4'hF;
    seg = 7'h00;
    repeat (3) @(negedge clk);
    chk("reset_digits", digits, 16'h0000);
    chk("reset_valid", 16'(valid), 16'h0);
    reset = 1'b0;

    // Basic frame 4321
    frames = 0;
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    chk("basic_frames", 16'(frames), 16'd1);
    chk("basic_digits", digits, 16'h4321);
    chk("basic_valid", 16'(valid), 16'h1);
    chk("basic_seg_err", 16'(seg_err), 16'h0);

    // Short dwell on slot 2 is ignored until a full dwell arrives
    frames = 0;
    hold(4'hE, 7'h7D, 8);
    hold(4'hD, 7'h5B, 8);
    hold(4'hB, 7'h4F, 3);
    hold(4'h7, 7'h66, 8);
    hold(4'hF, 7'h00, 6);
    chk("short_no_commit", 16'(frames), 16'd0);
    chk("short_digits_held", digits, 16'h4321);
    hold(4'hB, 7'h4F, 5);
    hold(4'hF, 7'h00, 6);
    chk("short_late_commit", 16'(frames), 16'd1);
    chk("short_digits", digits, 16'h4326);

    // Unrecognised pattern in slot 1, then a clean frame
    frames = 0;
    scan(7'h06, 7'h00, 7'h4F, 7'h66);
    chk("bad_digits", digits, 16'h4301);
    chk("bad_seg_err", 16'(seg_err), 16'h1);
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    chk("clean_seg_err", 16'(seg_err), 16'h0);
    chk("bad_frames", 16'(frames), 16'd2);

    // Two anodes low mid-scan
    frames = 0;
    hold(4'hE, 7'h06, 8);
    hold(4'hD, 7'h5B, 8);
    hold(4'hC, 7'h4F, 6);
    hold(4'hB, 7'h4F, 8);
    hold(4'h7, 7'h66, 8);
    hold(4'hF, 7'h00, 6);
    chk("anerr_set", 16'(an_err), 16'h1);
    chk("anerr_frames", 16'(frames), 16'd1);
    chk("anerr_digits", digits, 16'h4321);
    hold(4'hF, 7'h00, 10);
    chk("anerr_sticky", 16'(an_err), 16'h1);

    // Reset in the middle of a frame
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    frames = 0;
    hold(4'hE, 7'h06, 8);
    hold(4'hD, 7'h5B, 8);
    reset = 1'b1;
    an = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    hold(4'hB, 7'h4F, 8);
    hold(4'h7, 7'h66, 8);
    hold(4'hF, 7'h00, 6);
    chk("rst_frames", 16'(frames), 16'd0);
    chk("rst_digits", digits, 16'h0000);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_an_err", 16'(an_err), 16'h0);
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    chk("rst_frames_after", 16'(frames), 16'd1);
    chk("rst_digits_after", digits, 16'h4321);

    // Continuous scan of F0A5 with blanking between digits
    frames = 0;
    for (int r = 0; r < 3; r++) begin
      hold(4'hE, 7'h6D, 5); hold(4'hF, 7'h00, 2);
      hold(4'hD, 7'h77, 5); hold(4'hF, 7'h00, 2);
      hold(4'hB, 7'h3F, 5); hold(4'hF, 7'h00, 2);
      hold(4'h7, 7'h71, 5); hold(4'hF, 7'h00, 2);
    end
    hold(4'hF, 7'h00, 6);
    chk("cont_frames", 16'(frames), 16'd3);
    chk("cont_digits", digits, 16'hF0A5);
    chk("cont_an_err", 16'(an_err), 16'h0);
    chk("cont_seg_err", 16'(seg_err), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
